// File: rtl/write_arbiter.sv
// write_arbiter: round-robin ingress arbiter that streams one granted port's packet into SRAM.
// Latency: a request seen in IDLE is granted next cycle; an accepted beat reaches wea/link one cycle later; commit arrives with the last write.
// Backpressure: wr_ready tracks free-list availability, so a port is stalled while the free list is empty, with no beat loss.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_wr_sop/prio/vld/eop    per-port packet request, priority, beat valid, last-beat marker
//   i_wr_data                per-port beat data
//   o_wr_ready               one-hot grant/accept (combinational)
//   i_free_addr/empty        head of the manager's free list, list-empty flag
//   o_free_pop               pop the free list (combinational, once per accepted beat)
//   o_wea/addr/data_write    registered SRAM write port
//   o_link_*                 registered link record for the address just written
//   o_pkt_commit/commit_len  one-hot per-priority commit pulse and packet beat count

module write_arbiter #(
  parameter int num_of_ports       = 16,
  parameter int num_of_priorities  = 8,
  parameter int priority_width     = 3,
  parameter int address_width      = 12,
  parameter int arbiter_data_width = 64,
  parameter int len_width          = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [num_of_ports-1:0]                    i_wr_sop,
  input  logic [num_of_ports*priority_width-1:0]     i_wr_prio,
  input  logic [num_of_ports-1:0]                    i_wr_vld,
  input  logic [num_of_ports-1:0]                    i_wr_eop,
  input  logic [num_of_ports*arbiter_data_width-1:0] i_wr_data,
  output logic [num_of_ports-1:0]                    o_wr_ready,
  input  logic [address_width-1:0]                   i_free_addr,
  input  logic                                       i_free_empty,
  output logic                                       o_free_pop,
  output logic                                       o_wea,
  output logic [address_width-1:0]                   o_addr_write,
  output logic [arbiter_data_width-1:0]              o_data_write,
  output logic                                       o_link_valid,
  output logic [priority_width-1:0]                  o_link_prio,
  output logic [address_width-1:0]                  o_link_addr,
  output logic                                       o_link_last,
  output logic [num_of_priorities-1:0]               o_pkt_commit,
  output logic [len_width-1:0]                       o_commit_len
);

  localparam int PORT_W = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    r_state;
  logic [PORT_W-1:0]         r_grant;
  logic [PORT_W-1:0]         r_last_grant;
  logic [priority_width-1:0] r_cur_prio;
  logic [len_width-1:0]      r_beat_cnt;

  logic                          w_found;
  logic [PORT_W-1:0]             w_winner;
  logic [PORT_W-1:0]             w_idx;
  logic [priority_width-1:0]     w_winner_prio;
  logic                          w_stream;
  logic                          w_beat_vld;
  logic                          w_beat_eop;
  logic [arbiter_data_width-1:0] w_beat_data;
  logic                          w_accept;
  logic [len_width-1:0]          w_cnt_inc;

  // Round-robin search: start one past the previous winner and take the first requester.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_idx    = r_last_grant;
    for (int i = 1; i <= num_of_ports; i++) begin
      w_idx = PORT_W'((int'(r_last_grant) + i) % num_of_ports);
      if (!w_found && i_wr_sop[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_winner_prio = i_wr_prio[w_winner*priority_width +: priority_width];
  assign w_beat_vld    = i_wr_vld[r_grant];
  assign w_beat_eop    = i_wr_eop[r_grant];
  assign w_beat_data   = i_wr_data[r_grant*arbiter_data_width +: arbiter_data_width];

  // rst gates the combinational handshake so ready/pop stay low while reset is held,
  // even on the first reset cycle when the state register is still mid-packet.
  assign w_stream = (r_state == STREAM) && !rst;
  assign w_accept = w_stream && !i_free_empty && w_beat_vld;

  always_comb begin
    o_wr_ready = '0;
    if (w_stream && !i_free_empty) begin
      o_wr_ready[r_grant] = 1'b1;
    end
  end

  assign o_free_pop = w_accept;

  // Beat count saturates instead of wrapping so long packets report the maximum length.
  assign w_cnt_inc = (r_beat_cnt == {len_width{1'b1}}) ? r_beat_cnt : r_beat_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= PORT_W'(num_of_ports - 1);
      r_cur_prio   <= '0;
      r_beat_cnt   <= '0;
      o_wea        <= 1'b0;
      o_addr_write <= '0;
      o_data_write <= '0;
      o_link_valid <= 1'b0;
      o_link_prio  <= '0;
      o_link_addr  <= '0;
      o_link_last  <= 1'b0;
      o_pkt_commit <= '0;
      o_commit_len <= '0;
    end else begin
      o_wea        <= 1'b0;
      o_link_valid <= 1'b0;
      o_pkt_commit <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_cur_prio   <= w_winner_prio;
            r_beat_cnt   <= '0;
            r_state      <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            o_wea        <= 1'b1;
            o_link_valid <= 1'b1;
            o_addr_write <= i_free_addr;
            o_link_addr  <= i_free_addr;
            o_data_write <= w_beat_data;
            o_link_prio  <= r_cur_prio;
            o_link_last  <= w_beat_eop;
            r_beat_cnt   <= w_cnt_inc;
            if (w_beat_eop) begin
              // Commit lands in DONE, the same cycle as the final write.
              o_pkt_commit[r_cur_prio] <= 1'b1;
              o_commit_len             <= w_cnt_inc;
              r_state                  <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
module tb_write_arbiter;

  localparam int NP = 16;
  localparam int PW = 3;
  localparam int AW = 12;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   wr_sop;
  logic [NP*PW-1:0] wr_prio;
  logic [NP-1:0]   wr_vld;
  logic [NP-1:0]   wr_eop;
  logic [NP*DW-1:0] wr_data;
  logic [AW-1:0]   free_addr;
  logic            free_empty;

  logic [NP-1:0]   wr_ready;
  logic            free_pop;
  logic            wea;
  logic [AW-1:0]   addr_write;
  logic [DW-1:0]   data_write;
  logic            link_valid;
  logic [PW-1:0]   link_prio;
  logic [AW-1:0]   link_addr;
  logic            link_last;
  logic [7:0]      pkt_commit;
  logic [7:0]      commit_len;

  logic [NP-1:0]   s_wr_ready;
  logic            s_free_pop;
  logic            s_wea;
  logic [AW-1:0]   s_addr_write;
  logic [DW-1:0]   s_data_write;
  logic            s_link_valid;
  logic [PW-1:0]   s_link_prio;
  logic [AW-1:0]   s_link_addr;
  logic            s_link_last;
  logic [7:0]      s_pkt_commit;
  logic [2:0]      s_commit_len;

  write_arbiter u_dut (
    .clk(clk), .rst(rst),
    .i_wr_sop(wr_sop), .i_wr_prio(wr_prio), .i_wr_vld(wr_vld), .i_wr_eop(wr_eop),
    .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_free_addr(free_addr), .i_free_empty(free_empty), .o_free_pop(free_pop),
    .o_wea(wea), .o_addr_write(addr_write), .o_data_write(data_write),
    .o_link_valid(link_valid), .o_link_prio(link_prio), .o_link_addr(link_addr),
    .o_link_last(link_last), .o_pkt_commit(pkt_commit), .o_commit_len(commit_len)
  );

  // Same stimulus into a 3-bit length instance to exercise count saturation.
  write_arbiter #(.len_width(3)) u_sat (
    .clk(clk), .rst(rst),
    .i_wr_sop(wr_sop), .i_wr_prio(wr_prio), .i_wr_vld(wr_vld), .i_wr_eop(wr_eop),
    .i_wr_data(wr_data), .o_wr_ready(s_wr_ready),
    .i_free_addr(free_addr), .i_free_empty(free_empty), .o_free_pop(s_free_pop),
    .o_wea(s_wea), .o_addr_write(s_addr_write), .o_data_write(s_data_write),
    .o_link_valid(s_link_valid), .o_link_prio(s_link_prio), .o_link_addr(s_link_addr),
    .o_link_last(s_link_last), .o_pkt_commit(s_pkt_commit), .o_commit_len(s_commit_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [PW-1:0] prio;
    logic        last;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [PW-1:0] prio;
    int          len;
  } cm_t;

  wr_t wq[$];
  cm_t cq[$];
  wr_t mw;
  cm_t mc;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int commits_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] mkd(input int port, input int beat);
    return {8'(port), 24'hC0FFEE, 32'(beat)};
  endfunction

  // Scoreboard consumer: every write and commit must match the oldest expectation.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      chk("write_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) begin
        mw = wq.pop_front();
        chk("write_cycle", 64'(cyc), 64'(mw.cyc));
        chk("addr_write", 64'(addr_write), 64'(mw.addr));
        chk("link_addr", 64'(link_addr), 64'(mw.addr));
        chk("data_write", data_write, mw.data);
        chk("link_prio", 64'(link_prio), 64'(mw.prio));
        chk("link_last", 64'(link_last), 64'(mw.last));
        chk("link_valid", 64'(link_valid), 64'd1);
        chk("sat_wea", 64'(s_wea), 64'd1);
        chk("sat_data_write", s_data_write, mw.data);
      end
    end
    if (pkt_commit !== 8'd0) begin
      commits_seen++;
      chk("commit_expected", 64'(cq.size() > 0), 64'd1);
      if (cq.size() > 0) begin
        mc = cq.pop_front();
        chk("commit_cycle", 64'(cyc), 64'(mc.cyc));
        chk("pkt_commit", 64'(pkt_commit), 64'd1 << mc.prio);
        chk("commit_len", 64'(commit_len), 64'((mc.len > 255) ? 255 : mc.len));
        chk("commit_with_wea", 64'(wea), 64'd1);
        chk("sat_pkt_commit", 64'(s_pkt_commit), 64'd1 << mc.prio);
        chk("sat_commit_len", 64'(s_commit_len), 64'((mc.len > 7) ? 7 : mc.len));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one packet from a single port, holding each beat until accepted.
  // stall_at: beat index before which free_empty is held for stall_n cycles (-1 none).
  // abort_after: after this many accepted beats, assert rst and return (0 none).
  // exp_lat: expected cycles from request to first wr_ready (-1 unchecked).
  task automatic send_pkt(input int port, input int prio, input int nb, input int addr0,
                          input int stall_at, input int stall_n, input int abort_after,
                          input int exp_lat);
    int  sent = 0;
    int  stalls = 0;
    bit  granted = 0;
    bit  acc;
    wr_t w;
    cm_t c;
    wr_sop[port]            = 1'b1;
    wr_prio[port*PW +: PW]  = PW'(prio);
    wr_vld[port]            = 1'b1;
    wr_eop[port]            = (nb == 1);
    wr_data[port*DW +: DW]  = mkd(port, 0);
    free_addr               = AW'(addr0);
    free_empty              = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = 1'b0;
      if (!granted && wr_ready !== '0) begin
        granted = 1'b1;
        chk("grant_port", 64'(wr_ready), 64'd1 << port);
        if (exp_lat >= 0) chk("grant_latency", 64'(k), 64'(exp_lat));
      end
      if (granted) begin
        chk("wr_ready", 64'(wr_ready), free_empty ? 64'd0 : (64'd1 << port));
        acc = !free_empty;
        chk("free_pop", 64'(free_pop), 64'(acc));
        if (acc) begin
          w.cyc = cyc + 1; w.addr = AW'(addr0 + sent); w.data = mkd(port, sent);
          w.prio = PW'(prio); w.last = (sent == nb - 1);
          wq.push_back(w);
          if (sent == nb - 1) begin
            c.cyc = cyc + 1; c.prio = PW'(prio); c.len = nb;
            cq.push_back(c);
          end
        end
      end
      @(posedge clk);
      #1;
      if (granted) wr_sop[port] = 1'b0;
      if (acc) begin
        sent++;
        if (sent == nb) begin
          wr_vld[port] = 1'b0;
          wr_eop[port] = 1'b0;
          return;
        end
        if (sent == abort_after) begin
          rst          = 1'b1;
          wr_vld[port] = 1'b0;
          wr_eop[port] = 1'b0;
          return;
        end
        wr_data[port*DW +: DW] = mkd(port, sent);
        wr_eop[port]           = (sent == nb - 1);
        free_addr              = AW'(addr0 + sent);
      end
      if (sent == stall_at && stalls < stall_n) begin
        free_empty = 1'b1;
        stalls++;
      end else begin
        free_empty = 1'b0;
      end
    end
    chk("packet_timeout", 64'(sent), 64'(nb));
    wr_sop[port] = 1'b0;
    wr_vld[port] = 1'b0;
    wr_eop[port] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int  rr_order[5] = '{0, 5, 15, 0, 5};
    int  ng;
    int  last_g;
    int  seen_before;
    bit  acc;
    wr_t w;
    cm_t c;

    // Reset with every input high.
    rst = 1'b1; wr_sop = '1; wr_prio = '1; wr_vld = '1; wr_eop = '1; wr_data = '1;
    free_addr = '1; free_empty = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_free_pop", 64'(free_pop), 64'd0);
    chk("rst_wea", 64'(wea), 64'd0);
    chk("rst_addr_write", 64'(addr_write), 64'd0);
    chk("rst_data_write", data_write, 64'd0);
    chk("rst_link_valid", 64'(link_valid), 64'd0);
    chk("rst_link_prio", 64'(link_prio), 64'd0);
    chk("rst_link_addr", 64'(link_addr), 64'd0);
    chk("rst_link_last", 64'(link_last), 64'd0);
    chk("rst_pkt_commit", 64'(pkt_commit), 64'd0);
    chk("rst_commit_len", 64'(commit_len), 64'd0);
    chk("rst_sat_wr_ready", 64'(s_wr_ready), 64'd0);

    // Release with every port requesting: port 0 must win first.
    rst = 1'b0; wr_prio = '0; wr_vld = '0; wr_eop = '0; wr_data = '0;
    free_addr = 12'h005; free_empty = 1'b0;
    @(posedge clk);
    #1;
    wr_sop = '0; wr_vld[0] = 1'b1; wr_eop[0] = 1'b1; wr_data[0 +: DW] = mkd(0, 0);
    @(negedge clk);
    chk("first_grant_port0", 64'(wr_ready), 64'd1);
    chk("first_grant_pop", 64'(free_pop), 64'd1);
    w.cyc = cyc + 1; w.addr = 12'h005; w.data = mkd(0, 0); w.prio = 3'd0; w.last = 1'b1;
    wq.push_back(w);
    c.cyc = cyc + 1; c.prio = 3'd0; c.len = 1;
    cq.push_back(c);
    @(posedge clk);
    #1;
    wr_vld[0] = 1'b0; wr_eop[0] = 1'b0;
    idle(4);

    // Single 4-beat packet from port 3, prio 5.
    send_pkt(3, 5, 4, 'h010, -1, 0, 0, 1);
    idle(4);

    // Free-list exhaustion for 3 cycles mid-packet.
    send_pkt(9, 2, 5, 'h040, 2, 3, 0, 1);
    idle(4);

    // Reset after 2 of 5 beats: no commit, then a normal grant.
    seen_before = commits_seen;
    send_pkt(6, 1, 5, 'h060, -1, 0, 2, 1);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle_ready", 64'(wr_ready), 64'd0);
      chk("post_rst_no_pop", 64'(free_pop), 64'd0);
    end
    chk("abort_no_commit", 64'(commits_seen), 64'(seen_before));
    idle(1);
    send_pkt(7, 4, 2, 'h070, -1, 0, 0, 1);
    idle(4);

    // Round-robin among ports 0, 5, 15 with continuous 1-beat packets.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    free_addr = 12'h100;
    foreach (rr_order[i]) begin
      wr_sop[rr_order[i]] = 1'b1;
      wr_vld[rr_order[i]] = 1'b1;
      wr_eop[rr_order[i]] = 1'b1;
      wr_prio[rr_order[i]*PW +: PW] = PW'(rr_order[i] % 8);
      wr_data[rr_order[i]*DW +: DW] = mkd(rr_order[i], 0);
    end
    ng = 0;
    last_g = 0;
    for (int k = 0; k < 60 && ng < 5; k++) begin
      @(negedge clk);
      acc = 1'b0;
      if (wr_ready !== '0) begin
        acc = 1'b1;
        chk("rr_grant", 64'(wr_ready), 64'd1 << rr_order[ng]);
        chk("rr_pop", 64'(free_pop), 64'd1);
        if (ng > 0) chk("rr_gap", 64'(cyc - last_g), 64'd3);
        last_g = cyc;
        w.cyc = cyc + 1; w.addr = free_addr; w.data = mkd(rr_order[ng], 0);
        w.prio = PW'(rr_order[ng] % 8); w.last = 1'b1;
        wq.push_back(w);
        c.cyc = cyc + 1; c.prio = PW'(rr_order[ng] % 8); c.len = 1;
        cq.push_back(c);
        ng++;
      end
      @(posedge clk);
      #1;
      if (acc) free_addr = free_addr + 1'b1;
    end
    chk("rr_grant_count", 64'(ng), 64'd5);
    wr_sop = '0; wr_vld = '0; wr_eop = '0;
    idle(6);

    // Ten-beat packet: full-width count 10, 3-bit instance saturates at 7.
    send_pkt(12, 7, 10, 'h200, -1, 0, 0, 1);
    idle(6);

    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("commits_drained", 64'(cq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
